// File: rtl/pipelined_adder_checker.sv
// Online checker for a NUM_REG-deep pipelined adder: delays the operands, forms the reference sum and flags outp mismatches.
// Optional first-failure capture of fail_exp/fail_act is built when PA_CHECKER_CAPTURE_EN is defined.
module pipelined_adder_checker #(
   parameter int INP_DW  = 8,
   parameter int NUM_REG = 4,
   parameter int CNT_DW  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic [INP_DW-1:0] inp1,
   input  logic [INP_DW-1:0] inp2,
   input  logic [INP_DW:0]   outp,
   output logic              mismatch,
   output logic              err_sticky,
   output logic [CNT_DW-1:0] err_count,
   output logic [CNT_DW-1:0] chk_count,
   output logic              checking,
   output logic [INP_DW:0]   fail_exp,
   output logic [INP_DW:0]   fail_act,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2
   } state_e;

   localparam int FW = $clog2(NUM_REG + 1);
   localparam logic [CNT_DW-1:0] CNT_MAX = '1;

   state_e              state_q, state_d;
   logic [FW-1:0]       fill_q, fill_d;
   logic [INP_DW-1:0]   dl_a_q [NUM_REG];
   logic [INP_DW-1:0]   dl_b_q [NUM_REG];
   logic [INP_DW:0]     ref_sum;
   logic                compare;
   logic                fail;
   logic                mismatch_q, mismatch_d;
   logic                sticky_q, sticky_d;
   logic [CNT_DW-1:0]   err_q, err_d;
   logic [CNT_DW-1:0]   chk_q, chk_d;

   // Operand delay line matches the adder latency; it runs in every state so data is aligned on entering CHECK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REG; i++) begin
            dl_a_q[i] <= '0;
            dl_b_q[i] <= '0;
         end
      end else begin
         dl_a_q[0] <= inp1;
         dl_b_q[0] <= inp2;
         for (int i = 1; i < NUM_REG; i++) begin
            dl_a_q[i] <= dl_a_q[i-1];
            dl_b_q[i] <= dl_b_q[i-1];
         end
      end
   end

   assign ref_sum = {1'b0, dl_a_q[NUM_REG-1]} + {1'b0, dl_b_q[NUM_REG-1]};
   assign compare = (state_q == CHECK);
   assign fail    = compare && (outp != ref_sum);

   // Fill counter is loaded with NUM_REG; reaching zero lands in CHECK exactly NUM_REG cycles after FILL starts.
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = FILL;
               fill_d  = FW'(NUM_REG);
            end
         end
         FILL: begin
            if (!en) begin
               state_d = IDLE;
               fill_d  = '0;
            end else begin
               fill_d = fill_q - FW'(1);
               if (fill_q <= FW'(1)) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (!en) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            fill_d  = '0;
         end
      endcase
   end

   always_comb begin
      mismatch_d = fail;
      sticky_d   = sticky_q;
      err_d      = err_q;
      chk_d      = chk_q;
      if (clr) begin
         sticky_d = 1'b0;
         err_d    = '0;
         chk_d    = '0;
      end else begin
         if (compare && (chk_q != CNT_MAX)) begin
            chk_d = chk_q + CNT_DW'(1);
         end
         if (fail) begin
            sticky_d = 1'b1;
            if (err_q != CNT_MAX) begin
               err_d = err_q + CNT_DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fill_q     <= '0;
         mismatch_q <= 1'b0;
         sticky_q   <= 1'b0;
         err_q      <= '0;
         chk_q      <= '0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         mismatch_q <= mismatch_d;
         sticky_q   <= sticky_d;
         err_q      <= err_d;
         chk_q      <= chk_d;
      end
   end

`ifdef PA_CHECKER_CAPTURE_EN
   logic [INP_DW:0] fexp_q, fexp_d;
   logic [INP_DW:0] fact_q, fact_d;

   // The sticky flag marks that a failure is already held, so only the first one after reset/clr is latched.
   always_comb begin
      fexp_d = fexp_q;
      fact_d = fact_q;
      if (clr) begin
         fexp_d = '0;
         fact_d = '0;
      end else if (fail && !sticky_q) begin
         fexp_d = ref_sum;
         fact_d = outp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fexp_q <= '0;
         fact_q <= '0;
      end else begin
         fexp_q <= fexp_d;
         fact_q <= fact_d;
      end
   end

   assign fail_exp = fexp_q;
   assign fail_act = fact_q;
`else
   assign fail_exp = '0;
   assign fail_act = '0;
`endif

   assign mismatch   = mismatch_q;
   assign err_sticky = sticky_q;
   assign err_count  = err_q;
   assign chk_count  = chk_q;
   assign checking   = (state_q == CHECK);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipelined_adder_checker.sv
// Bench for pipelined_adder_checker: golden adder feeds outp, a run-length/queue model predicts every checker output.
`timescale 1ns/1ps
module tb_pipelined_adder_checker;

   localparam int INP_DW  = 8;
   localparam int NUM_REG = 4;
`ifdef PA_CHECKER_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  inp1 = '0;
   logic [7:0]  inp2 = '0;
   logic [8:0]  outp;
   logic [8:0]  gold_pipe [NUM_REG];
   logic [8:0]  flip_mask = '0;
   logic        ovr_en = 1'b0;
   logic [8:0]  ovr_val = '0;
   logic [7:0]  up_cnt = '0;
   logic [7:0]  dn_cnt = '0;

   logic        mismatch, err_sticky, checking;
   logic [15:0] err_count, chk_count;
   logic [8:0]  fail_exp, fail_act;
   logic [1:0]  dbg_state;
   logic        s_mismatch, s_err_sticky, s_checking;
   logic [1:0]  s_err_count, s_chk_count;
   logic [8:0]  s_fail_exp, s_fail_act;
   logic [1:0]  s_dbg_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_adder_checker #(.INP_DW(INP_DW), .NUM_REG(NUM_REG), .CNT_DW(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .inp1(inp1), .inp2(inp2), .outp(outp),
      .mismatch(mismatch), .err_sticky(err_sticky), .err_count(err_count), .chk_count(chk_count),
      .checking(checking), .fail_exp(fail_exp), .fail_act(fail_act), .dbg_state(dbg_state)
   );

   pipelined_adder_checker #(.INP_DW(INP_DW), .NUM_REG(NUM_REG), .CNT_DW(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .inp1(inp1), .inp2(inp2), .outp(outp),
      .mismatch(s_mismatch), .err_sticky(s_err_sticky), .err_count(s_err_count), .chk_count(s_chk_count),
      .checking(s_checking), .fail_exp(s_fail_exp), .fail_act(s_fail_act), .dbg_state(s_dbg_state)
   );

   // Golden adder: NUM_REG-deep sum pipeline, with fault injection and override on its output.
   initial for (int i = 0; i < NUM_REG; i++) gold_pipe[i] = '0;
   always @(posedge clk) begin
      gold_pipe[0] <= {1'b0, inp1} + {1'b0, inp2};
      for (int i = 1; i < NUM_REG; i++) gold_pipe[i] <= gold_pipe[i-1];
   end
   assign outp = ovr_en ? ovr_val : (gold_pipe[NUM_REG-1] ^ flip_mask);

   // Reference model: a compare happens once en has been high NUM_REG+1 consecutive cycles.
   logic        m_mismatch = 1'b0;
   logic        m_sticky = 1'b0;
   int unsigned m_err = 0, m_chk = 0, m_err_s = 0, m_chk_s = 0;
   logic [8:0]  m_fexp = '0, m_fact = '0, m_exp;
   logic        m_in_chk, m_bad;
   int          run = 0;
   logic [8:0]  hist [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mismatch = 1'b0; m_sticky = 1'b0;
         m_err = 0; m_chk = 0; m_err_s = 0; m_chk_s = 0;
         m_fexp = '0; m_fact = '0; run = 0;
      end else begin
         m_in_chk = (run >= NUM_REG + 1);
         m_exp = hist[$-(NUM_REG-1)];
         m_bad = m_in_chk && (outp !== m_exp);
         m_mismatch = m_bad;
         if (clr) begin
            m_sticky = 1'b0; m_err = 0; m_chk = 0; m_err_s = 0; m_chk_s = 0;
            m_fexp = '0; m_fact = '0;
         end else begin
            if (m_in_chk) begin
               if (m_chk < 65535) m_chk++;
               if (m_chk_s < 3) m_chk_s++;
            end
            if (m_bad) begin
               if (m_err < 65535) m_err++;
               if (m_err_s < 3) m_err_s++;
               if (!m_sticky && CAP) begin
                  m_fexp = m_exp;
                  m_fact = outp;
               end
               m_sticky = 1'b1;
            end
         end
         run = en ? ((run < 1000) ? run + 1 : run) : 0;
         hist.push_back({1'b0, inp1} + {1'b0, inp2});
         void'(hist.pop_front());
      end
   end

   function automatic logic [74:0] exp_vec();
      return {m_mismatch, m_sticky, 1'(run >= NUM_REG + 1), 16'(m_err), 16'(m_chk), m_fexp, m_fact,
              2'(m_err_s), 2'(m_chk_s), m_fexp, m_fact};
   endfunction

   function automatic logic [74:0] obs_vec();
      return {mismatch, err_sticky, checking, err_count, chk_count, fail_exp, fail_act,
              s_err_count, s_chk_count, s_fail_exp, s_fail_act};
   endfunction

   task automatic set_inputs(input bit counting);
      if (counting) begin
         inp1 = up_cnt; inp2 = dn_cnt;
         up_cnt++; dn_cnt--;
      end else begin
         inp1 = 8'($urandom); inp2 = 8'($urandom);
      end
   endtask

   task automatic tick(input bit counting);
      set_inputs(counting);
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (obs_vec() !== 75'd0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_values: got %h state %0d expected all zero", obs_vec(), dbg_state);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL idle_after_reset: got %h expected %h", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_clean_run();
      up_cnt = '0; dn_cnt = '0;
      en = 1'b1;
      for (int i = 0; i < 301; i++) begin
         if (i == 300) en = 1'b0;
         tick(1'b1);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL clean_run cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (chk_count !== 16'd296 || err_sticky !== 1'b0 || err_count !== 16'd0) begin
         failures++;
         $display("FAIL clean_run_totals: got chk=%0d err=%0d sticky=%b expected chk=296 err=0 sticky=0",
                  chk_count, err_count, err_sticky);
      end
   endtask

   task automatic test_single_fault();
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL single_fault_fill: got %h expected %h", obs_vec(), exp_vec());
         end
      end
      flip_mask = 9'h001;
      tick(1'b1);
      flip_mask = '0;
      checks++;
      if (mismatch !== 1'b1 || err_count !== 16'd1 || err_sticky !== 1'b1 ||
          fail_exp !== (CAP ? 9'h100 : 9'h000) || fail_act !== (CAP ? 9'h101 : 9'h000)) begin
         failures++;
         $display("FAIL single_fault: got mm=%b err=%0d sticky=%b exp=%h act=%h", mismatch, err_count,
                  err_sticky, fail_exp, fail_act);
      end
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec() || mismatch !== 1'b0) begin
         failures++;
         $display("FAIL single_fault_pulse_end: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 5; k++) begin
         flip_mask = 9'($urandom_range(1, 511));
         tick(1'b0);
         flip_mask = '0;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL saturation_fault %0d: got %h expected %h", k, obs_vec(), exp_vec());
         end
         tick(1'b0);
      end
      checks++;
      if (s_err_count !== 2'd3 || s_chk_count !== 2'd3 || err_count !== 16'd6 ||
          s_fail_exp !== (CAP ? 9'h100 : 9'h000) || s_fail_act !== (CAP ? 9'h101 : 9'h000)) begin
         failures++;
         $display("FAIL saturation: got s_err=%0d s_chk=%0d err=%0d exp=%h act=%h", s_err_count,
                  s_chk_count, err_count, s_fail_exp, s_fail_act);
      end
   endtask

   task automatic test_gating();
      int rise;
      en = 1'b0;
      tick(1'b0);
      tick(1'b0);
      clr = 1'b1;
      tick(1'b0);
      clr = 1'b0;
      ovr_en = 1'b1; ovr_val = 9'h0AA;
      for (int i = 0; i < 3; i++) tick(1'b0);
      en = 1'b1;
      rise = -1;
      for (int i = 0; i < 10 && rise < 0; i++) begin
         tick(1'b0);
         if (checking === 1'b1) begin
            rise = i + 1;
            ovr_en = 1'b0;
         end
         checks++;
         if (obs_vec() !== exp_vec() || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL gating cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      ovr_en = 1'b0;
      checks++;
      if (rise !== 5) begin
         failures++;
         $display("FAIL gating_latency: got %0d cycles expected 5", rise);
      end
   endtask

   task automatic test_clear_collision();
      for (int i = 0; i < 3; i++) tick(1'b0);
      flip_mask = 9'h004;
      tick(1'b0);
      flip_mask = '0;
      tick(1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || err_count !== 16'd1) begin
         failures++;
         $display("FAIL collision_setup: got %h expected %h", obs_vec(), exp_vec());
      end
      flip_mask = 9'h001; clr = 1'b1;
      tick(1'b0);
      flip_mask = '0; clr = 1'b0;
      checks++;
      if (mismatch !== 1'b1 || err_count !== 16'd0 || err_sticky !== 1'b0 || fail_exp !== 9'd0 ||
          fail_act !== 9'd0 || chk_count !== 16'd0) begin
         failures++;
         $display("FAIL clear_collision: got mm=%b err=%0d sticky=%b exp=%h act=%h chk=%0d", mismatch,
                  err_count, err_sticky, fail_exp, fail_act, chk_count);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL clear_collision_model: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_mid_check();
      int rise;
      for (int k = 0; k < 2; k++) begin
         flip_mask = 9'($urandom_range(1, 511));
         tick(1'b0);
         flip_mask = '0;
         tick(1'b0);
      end
      checks++;
      if (err_count !== 16'd2 || checking !== 1'b1) begin
         failures++;
         $display("FAIL reset_setup: got err=%0d checking=%b expected err=2 checking=1", err_count, checking);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== 75'd0 || mismatch !== 1'b0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL async_reset: got %h state %0d expected all zero", obs_vec(), dbg_state);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rise = -1;
      for (int i = 0; i < 10 && rise < 0; i++) begin
         tick(1'b0);
         if (checking === 1'b1) rise = i + 1;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL refill cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (rise !== 5) begin
         failures++;
         $display("FAIL refill_latency: got %0d cycles expected 5", rise);
      end
      for (int i = 0; i < 3; i++) tick(1'b0);
      checks++;
      if (chk_count !== 16'd3 || obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL checks_resume: got chk=%0d vec %h expected chk=3 vec %h", chk_count, obs_vec(), exp_vec());
      end
      en = 1'b0;
      tick(1'b0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) hist.push_back(9'd0);
      test_reset();
      test_clean_run();
      test_single_fault();
      test_saturation();
      test_gating();
      test_clear_collision();
      test_reset_mid_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/pipelined_adder_checker.md
# pipelined_adder_checker

Self-checking monitor placed directly downstream of `pipelined_adder`. It taps the same operands the adder receives, delays them by the adder's latency, forms the reference sum and compares it against the adder's `outp` every cycle. It reports per-cycle mismatches, a sticky error flag and saturating counters, so hardware test wrappers can flag adder faults without a simulator.

## Interface
- `INP_DW`, 8: operand width. The sum is `INP_DW+1` bits.
- `NUM_REG`, 4: adder latency in cycles from operands to `outp`. Legal range is 1..16.
- `CNT_DW`, 16: width of `err_count` and `chk_count`.

- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: checking enable (level).
- `clr`  in  1: synchronous clear of counters, sticky flag and capture registers.
- `inp1`  in  `INP_DW`: operand A, as presented to the adder.
- `inp2`  in  `INP_DW`: operand B, as presented to the adder.
- `outp`  in  `INP_DW+1`: adder result.
- `mismatch`  out  1: registered one-cycle pulse per failed compare.
- `err_sticky`  out  1: set on the first mismatch; held until reset or `clr`.
- `err_count`  out  `CNT_DW`: mismatch count, saturating.
- `chk_count`  out  `CNT_DW`: compare count, saturating.
- `checking`  out  1: high while in state CHECK.
- `fail_exp`  out  `INP_DW+1`: expected value at the first mismatch.
- `fail_act`  out  `INP_DW+1`: actual value at the first mismatch.

## Operation
- Delay line: `NUM_REG` stages of `{inp1, inp2}`.
  - Shifts every cycle, regardless of state.
  - Cleared to 0 by reset only.
- Reference sum is `{1'b0,a} + {1'b0,b}` on the delay-line tail, at full `INP_DW+1` width with no truncation.
- FSM:
  - IDLE: `en=1` moves to FILL and loads the fill counter with `NUM_REG`.
  - FILL: the counter decrements each cycle. At 0 with `en=1`, go to CHECK. If `en=0`, go to IDLE.
  - CHECK: one compare per cycle. `en=0` moves to IDLE on the next edge.
- Compares happen only in CHECK. Bad `outp` in IDLE or FILL is ignored.
- On each compare, `chk_count` increments. On inequality:
  - `mismatch` pulses;
  - `err_count` increments;
  - `err_sticky` is set.
- Both counters saturate at `2^CNT_DW-1` and do not wrap.
- Leaving CHECK does not clear the counters. Only `clr` or reset does.
- `clr` effects:
  - zeroes `err_count`, `chk_count`, `err_sticky`, `fail_exp` and `fail_act`;
  - does not change the FSM state or the delay line;
  - `clr` together with a mismatch in the same cycle: `clr` wins, every cleared output reads 0 next cycle, and `mismatch` still pulses.

## Timing
- Reset values: every output 0, FSM in IDLE, fill counter 0.
- Compare at edge t uses `outp(t)` against `inp1(t-NUM_REG) + inp2(t-NUM_REG)`.
- `mismatch`, the counters and `err_sticky` update on edge t, visible in cycle t+1.
- Enable timing:
  - `en` rises in cycle e, so FILL starts at e+1.
  - CHECK starts at e+1+`NUM_REG`.
  - `checking` is high from that cycle onward.
- Reset asserted mid-CHECK returns every output to 0 immediately (asynchronous). After `rst_n` rises, the block restarts from IDLE and requires a full FILL.

## Configuration
- `PA_CHECKER_CAPTURE_EN` defined:
  - `fail_exp` and `fail_act` latch the expected and actual values of the first mismatch after reset or `clr`;
  - later mismatches do not overwrite them.
- `PA_CHECKER_CAPTURE_EN` undefined:
  - the capture registers are not built;
  - `fail_exp` and `fail_act` are tied to 0;
  - all other behaviour is unchanged.

## Test plan
All scenarios use `NUM_REG=4`, `INP_DW=8` and a golden adder model. Stimulus is `inp1` counting up from 0 and `inp2` counting down from 0.
- Clean run: `en=1` for 300 cycles, expecting `outp = 9'h100` except `9'h000` when both operands are 0. Required: `mismatch` never high, `err_sticky=0`, and `chk_count` equals the cycles spent in CHECK (296).
- Single fault: in CHECK, flip `outp[0]` for one cycle so `9'h100` reads `9'h101`. Required: one `mismatch` pulse one cycle later, `err_count=1`, `err_sticky=1`, and with the macro defined `fail_exp=9'h100`, `fail_act=9'h101`.
- Saturation: build with `CNT_DW=2` and inject 5 faults. Required: `err_count` stays at 3 and `fail_exp`/`fail_act` hold the values from the first fault.
- Gating: hold `outp` at `9'h0AA` while in IDLE and FILL. Required: no `mismatch`, and `checking` rises exactly 5 cycles after `en` rises.
- Clear collision: assert `clr` in the same cycle as a fault. Required: `mismatch` pulses and `err_count=0`, `err_sticky=0`, `fail_exp=0` next cycle.
- Reset mid-CHECK: drop `rst_n` with `err_count=2`. Required: all outputs 0 immediately. After release with `en` held at 1, the FSM re-enters FILL and checks resume 5 cycles later.
